// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code constants, FSM state
// encoding and the flag bundle. Also used by decode and by the testbench.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic cout;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        unique case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MULU: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback bundle of the sequential ALU.
//  in_valid/in_ready   : issue handshake carrying op, src1, src2
//  out_valid/out_ready : writeback handshake carrying result and flags
// master = issue/writeback side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow, illegal
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow, illegal
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, WIDTH cycles.
//  clk, rst_n : clock, synchronous active-low reset (control state only)
//  start      : latch mcand/mplier and begin iterating
//  mcand      : multiplicand
//  mplier     : multiplier
//  busy       : iterations in progress
//  done       : high during the last iteration; product is valid that cycle
//  product    : value the accumulator takes at the end of this cycle
//               (full 2*WIDTH product while done is high)
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    // Upper half accumulates partial sums, lower half holds the multiplier
    // bits not yet consumed; the whole thing shifts right each iteration.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     partial;

    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_nxt = {partial, acc_q[WIDTH-1:1]};
    end

    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy    = busy_q;
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q <= mcand;
            acc_q   <= {{WIDTH{1'b0}}, mplier};
        end else if (busy_q) begin
            acc_q <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU between decode/issue and writeback. Single-cycle ops are
// evaluated on accept and registered; MULU runs on alu_mul_seq for WIDTH
// cycles. Result and flags hold while out_valid and not out_ready.
//  clk    : rising-edge clock
//  rst_n  : synchronous active-low reset; discards any in-flight op
//  bus    : alu_seq_if slave (in_valid/in_ready/op/src1/src2,
//           out_valid/out_ready/result/zero/cout/overflow/illegal)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    alu_state_t state_q;
    alu_state_t state_d;
    logic       in_ready_c;
    logic       accept;
    logic       is_mul;
    logic       mul_start;
    logic       mul_busy;
    logic       mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_ill;

    logic [WIDTH-1:0] result_p1;
    alu_flags_t       flags_p1;

    // Single-cycle ops. MULU and illegal codes yield result 0 here; MULU is
    // completed by the multiplier.
    function automatic void alu_eval(
        input  logic [3:0]       op,
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        output logic [WIDTH-1:0] res,
        output logic             cout,
        output logic             ovf,
        output logic             ill
    );
        logic [SHW-1:0]          sh;
        logic [WIDTH:0]          sum;
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic signed [WIDTH-1:0] sra_s;
        sh    = b[SHW-1:0];
        a_s   = $signed(a);
        b_s   = $signed(b);
        sra_s = a_s >>> sh;
        sum   = '0;
        res   = '0;
        cout  = 1'b0;
        ovf   = 1'b0;
        ill   = !op_is_legal(op);
        unique case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry out of a + ~b + 1: 1 means no borrow
                sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res[0] = (a_s < b_s);
            OP_SLL: res = a << sh;
            OP_SRL: res = a >> sh;
            OP_SRA: res = sra_s;
            default: res = '0;
        endcase
    endfunction

    assign is_mul    = (bus.op == OP_MULU);
    assign mul_start = accept && is_mul;

    always_comb begin
        alu_eval(bus.op, bus.src1, bus.src2, alu_res, alu_cout, alu_ovf, alu_ill);
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .mcand   (bus.src1),
        .mplier  (bus.src2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake. In DONE a new op is taken in the same cycle
    // the current result drains, giving one op per cycle under full flow.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                if (accept) begin
                    state_d = is_mul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (mul_done && mul_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready_c = bus.out_ready;
                accept     = bus.in_valid && bus.out_ready;
                if (bus.out_ready) begin
                    if (accept) begin
                        state_d = is_mul ? ST_BUSY : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage: loaded on a single-cycle accept or on the last multiply
    // iteration; otherwise held, which keeps it stable under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_p1 <= '0;
            flags_p1  <= '0;
        end else if (accept && !is_mul) begin
            result_p1         <= alu_res;
            flags_p1.zero     <= (alu_res == '0);
            flags_p1.cout     <= alu_cout;
            flags_p1.overflow <= alu_ovf;
            flags_p1.illegal  <= alu_ill;
        end else if (mul_done) begin
            result_p1         <= mul_prod[WIDTH-1:0];
            flags_p1.zero     <= (mul_prod[WIDTH-1:0] == '0);
            flags_p1.cout     <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_p1.overflow <= 1'b0;
            flags_p1.illegal  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_p1;
    assign bus.zero      = flags_p1.zero;
    assign bus.cout      = flags_p1.cout;
    assign bus.overflow  = flags_p1.overflow;
    assign bus.illegal   = flags_p1.illegal;

endmodule
